qspim_sck_gen: RTL and testbench
================================

# qspim_sck_gen

Parametrised SPI serial-clock generator for the QSPI master, replacing the fixed 6-bit free-running clock generator. It supports a configurable divider width, per-chip-select period and SPI mode (CPOL/CPHA), and bursts of a programmed number of SCK cycles. It also supports stall, abort and done handshakes. The block sits between the QSPI control FSM (start/stall/abort, burst length) and the shift-register datapath (shift/sample strobes) and pad logic (spi_clk).

## Interface
- CNT_W, default 8: width of each per-CS period field; period range 2..2^CNT_W-1.
- NUM_CS, default 4: number of chip-select configuration slots (>=1).
- CYC_W, default 6: width of burst-length field.
- clk  in  1  system clock.
- rstn  in  1  reset, asynchronous, active-low.
- cfg_sck_period  in  NUM_CS*CNT_W  per-CS SCK period in clk cycles; slot i at [i*CNT_W +: CNT_W].
- cfg_cpol  in  NUM_CS  per-CS idle level of spi_clk.
- cfg_cpha  in  NUM_CS  per-CS phase: 0 = sample leading/shift trailing, 1 = shift leading/sample trailing.
- cs_sel  in  max(1,$clog2(NUM_CS))  config slot used by next burst.
- burst_cycles  in  CYC_W  SCK cycles in burst minus 1.
- start  in  1  one-cycle burst request.
- sck_stall  in  1  freeze SCK in current phase.
- abort  in  1  terminate burst.
- busy  out  1  burst in progress.
- done  out  1  one-cycle pulse on normal burst completion.
- spi_clk  out  1  serial clock to pad.
- spi_rise / spi_fall  out  1  one-cycle pulse the cycle before spi_clk rises/falls.
- spi_shift / spi_sample  out  1  one-cycle launch / capture strobes.
- spi_last  out  1  asserted with the final trailing-edge pulse of a burst.

## Operation
- States: IDLE, RUN. No other states.
- Reset: state IDLE, spi_clk=1, busy=done=spi_rise=spi_fall=spi_shift=spi_sample=spi_last=0, counters 0.
- IDLE: spi_clk <= cfg_cpol[cs_sel] every cycle. start=1 and abort=0 latches period P, cpol, cpha (slot cs_sel) and N=burst_cycles+1. Then it goes to RUN with busy=1 next cycle.
- P<2 is treated as 2. H = P>>1 is the first-half length; second half is P-H (odd P gives the longer second half).
- RUN: phase counter counts clk cycles. Leading-edge pulse fires H cycles after start was sampled; trailing-edge pulse fires P cycles after start; pattern repeats every P cycles for N SCK cycles.
- Leading edge: spi_fall if cpol=1, else spi_rise. Trailing edge is the opposite.
- cpha=0: spi_sample with leading, spi_shift with trailing. cpha=1: spi_shift with leading, spi_sample with trailing.
- spi_clk toggles the cycle after each rise/fall pulse.
- Final (Nth) trailing pulse also asserts spi_last. Next cycle: spi_clk at idle level, done=1, busy=0, state IDLE.
- sck_stall=1 in RUN: counters hold, no pulses, spi_clk holds; all later edges slip by the stall length. Stall in IDLE has no effect.
- abort=1 in RUN: next cycle spi_clk=cpol, busy=0, state IDLE; no pulses in that cycle, no done. abort beats stall and a pending edge.
- start while busy is ignored. start with abort in IDLE is ignored.
- Config inputs are sampled only at start; changes during RUN have no effect.
- The burst counter of CYC_W bits wraps only at terminal count; burst_cycles = 2^CYC_W-1 gives 2^CYC_W cycles.

## Timing
- Start-to-first-edge pulse: H cycles; spi_clk first transition at H+1.
- Burst length: busy high cycles 1..N*P (plus stall cycles); done at N*P+1.
- Back-to-back: start in the done cycle is accepted (state already IDLE).
- All outputs registered; no combinational input-to-output path.
- Mid-burst asynchronous reset: all outputs immediately reset values; spi_clk=1 regardless of cpol.

## Test plan
- Reset, then P=4, cpol=1, cpha=0, N=2, start at t0 -> spi_fall+spi_sample at t2 and t6; spi_rise+spi_shift at t4 and t8; spi_last at t8; done at t9; spi_clk=1 at t9.
- Slot 2: P=5, cpol=0, cpha=1, N=1 -> spi_rise+spi_shift at t2, spi_fall+spi_sample+spi_last at t5, done at t6; spi_clk low 3 cycles after rise... high t3–t5, low from t6.
- P=4, N=1, sck_stall high cycles t1–t3 -> leading pulse at t5, trailing at t7, done at t8.
- abort at t3 of P=8, N=4, cpol=1 -> spi_clk=1 and busy=0 at t4, no done, no pulses from t4; start at t5 accepted.
- Pulse start during busy and switch cs_sel/cfg_sck_period mid-burst -> timing unchanged and no second burst. cfg P=0 or 1 behaves as P=2.
- burst_cycles=63 with CYC_W=6, P=2 -> 64 spi_sample pulses, done at t129.

Source files
------------

// File: rtl/qspim_sck_gen.sv
// SPI serial-clock generator for the QSPI master. It produces bursts of N SCK cycles
// with a per-chip-select period and mode, plus registered edge, shift and sample strobes.
module qspim_sck_gen #(
  parameter int CNT_W  = 8,
  parameter int NUM_CS = 4,
  parameter int CYC_W  = 6,
  localparam int CS_W  = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CS*CNT_W-1:0] cfg_sck_period,
  input  logic [NUM_CS-1:0]       cfg_cpol,
  input  logic [NUM_CS-1:0]       cfg_cpha,
  input  logic [CS_W-1:0]         cs_sel,
  input  logic [CYC_W-1:0]        burst_cycles,
  input  logic                    start,
  input  logic                    sck_stall,
  input  logic                    abort,
  output logic                    busy,
  output logic                    done,
  output logic                    spi_clk,
  output logic                    spi_rise,
  output logic                    spi_fall,
  output logic                    spi_shift,
  output logic                    spi_sample,
  output logic                    spi_last
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  logic [0:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] per_q, per_d;
  logic [CNT_W-1:0] half_q, half_d;
  logic [CYC_W-1:0] bcnt_q, bcnt_d;
  logic [CYC_W-1:0] ncyc_q, ncyc_d;
  logic             cpol_q, cpol_d;
  logic             cpha_q, cpha_d;
  logic             clk_q, clk_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             shift_q, shift_d;
  logic             sample_q, sample_d;
  logic             last_q, last_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] sel_per;
  logic             sel_cpol;
  logic             sel_cpha;
  logic [CNT_W-1:0] cnt_inc;
  logic             lead_ev;
  logic             trail_ev;

  // Slot lookup; an out-of-range cs_sel falls back to slot 0.
  always_comb begin
    sel_per  = cfg_sck_period[CNT_W-1:0];
    sel_cpol = cfg_cpol[0];
    sel_cpha = cfg_cpha[0];
    for (int i = 1; i < NUM_CS; i++) begin
      if (cs_sel == CS_W'(i)) begin
        sel_per  = cfg_sck_period[i*CNT_W +: CNT_W];
        sel_cpol = cfg_cpol[i];
        sel_cpha = cfg_cpha[i];
      end
    end
    if (sel_per < CNT_W'(2)) begin
      sel_per = CNT_W'(2);
    end
  end

  assign cnt_inc = cnt_q + CNT_W'(1);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    per_d    = per_q;
    half_d   = half_q;
    bcnt_d   = bcnt_q;
    ncyc_d   = ncyc_q;
    cpol_d   = cpol_q;
    cpha_d   = cpha_q;
    clk_d    = clk_q;
    rise_d   = 1'b0;
    fall_d   = 1'b0;
    shift_d  = 1'b0;
    sample_d = 1'b0;
    last_d   = 1'b0;
    done_d   = 1'b0;
    lead_ev  = 1'b0;
    trail_ev = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clk_d = sel_cpol;
        if (start && !abort) begin
          state_d = ST_RUN;
          per_d   = sel_per;
          half_d  = sel_per >> 1;
          cpol_d  = sel_cpol;
          cpha_d  = sel_cpha;
          ncyc_d  = burst_cycles;
          bcnt_d  = '0;
          cnt_d   = CNT_W'(1);
          // The start cycle counts as the first phase step, so H=1 fires immediately.
          lead_ev = ((sel_per >> 1) == CNT_W'(1));
        end
      end
      default: begin
        if (abort) begin
          state_d = ST_IDLE;
          clk_d   = cpol_q;
          cnt_d   = '0;
          bcnt_d  = '0;
        end else if (last_q) begin
          state_d = ST_IDLE;
          clk_d   = cpol_q;
          done_d  = 1'b1;
          cnt_d   = '0;
          bcnt_d  = '0;
        end else begin
          // An edge already announced by a pulse still completes during a stall.
          if (rise_q) clk_d = 1'b1;
          if (fall_q) clk_d = 1'b0;
          if (!sck_stall) begin
            lead_ev = (cnt_inc == half_q);
            if (cnt_inc == per_q) begin
              trail_ev = 1'b1;
              cnt_d    = '0;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
      end
    endcase

    if (lead_ev) begin
      rise_d   = ~cpol_d;
      fall_d   = cpol_d;
      shift_d  = cpha_d;
      sample_d = ~cpha_d;
    end
    if (trail_ev) begin
      rise_d   = cpol_d;
      fall_d   = ~cpol_d;
      shift_d  = ~cpha_d;
      sample_d = cpha_d;
      last_d   = (bcnt_q == ncyc_q);
      bcnt_d   = bcnt_q + CYC_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      per_q    <= '0;
      half_q   <= '0;
      bcnt_q   <= '0;
      ncyc_q   <= '0;
      cpol_q   <= 1'b0;
      cpha_q   <= 1'b0;
      clk_q    <= 1'b1;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
      shift_q  <= 1'b0;
      sample_q <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      per_q    <= per_d;
      half_q   <= half_d;
      bcnt_q   <= bcnt_d;
      ncyc_q   <= ncyc_d;
      cpol_q   <= cpol_d;
      cpha_q   <= cpha_d;
      clk_q    <= clk_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
      shift_q  <= shift_d;
      sample_q <= sample_d;
      last_q   <= last_d;
      done_q   <= done_d;
    end
  end

  assign busy       = (state_q == ST_RUN);
  assign done       = done_q;
  assign spi_clk    = clk_q;
  assign spi_rise   = rise_q;
  assign spi_fall   = fall_q;
  assign spi_shift  = shift_q;
  assign spi_sample = sample_q;
  assign spi_last   = last_q;

endmodule

// File: tb/tb_qspim_sck_gen.sv
// Scoreboard bench for qspim_sck_gen: directed bursts push hand-computed strobe events,
// and a negedge monitor pops and compares them whenever the DUT emits a strobe or done.
module tb_qspim_sck_gen;

  localparam int CNT_W  = 8;
  localparam int NUM_CS = 4;
  localparam int CYC_W  = 6;

  localparam logic [5:0] R  = 6'b100000;
  localparam logic [5:0] F  = 6'b010000;
  localparam logic [5:0] SH = 6'b001000;
  localparam logic [5:0] SA = 6'b000100;
  localparam logic [5:0] L  = 6'b000010;
  localparam logic [5:0] D  = 6'b000001;

  logic                    clk = 1'b0;
  logic                    rstn;
  logic [NUM_CS*CNT_W-1:0] cfg_sck_period;
  logic [NUM_CS-1:0]       cfg_cpol;
  logic [NUM_CS-1:0]       cfg_cpha;
  logic [1:0]              cs_sel;
  logic [CYC_W-1:0]        burst_cycles;
  logic                    start;
  logic                    sck_stall;
  logic                    abort;
  logic                    busy, done, spi_clk, spi_rise, spi_fall;
  logic                    spi_shift, spi_sample, spi_last;

  qspim_sck_gen #(.CNT_W(CNT_W), .NUM_CS(NUM_CS), .CYC_W(CYC_W)) dut (
    .clk(clk), .rstn(rstn), .cfg_sck_period(cfg_sck_period), .cfg_cpol(cfg_cpol),
    .cfg_cpha(cfg_cpha), .cs_sel(cs_sel), .burst_cycles(burst_cycles), .start(start),
    .sck_stall(sck_stall), .abort(abort), .busy(busy), .done(done), .spi_clk(spi_clk),
    .spi_rise(spi_rise), .spi_fall(spi_fall), .spi_shift(spi_shift),
    .spi_sample(spi_sample), .spi_last(spi_last)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [5:0] fl;
    logic       ck;
    logic       bz;
  } exp_t;

  exp_t       q[$];
  exp_t       mon_e;
  logic [5:0] mon_act;
  int         cyc = 0;
  int         checks = 0;
  int         failures = 0;
  int         t0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic push(input int c, input logic [5:0] fl, input logic ck, input logic bz);
    exp_t e;
    e.cyc = c; e.fl = fl; e.ck = ck; e.bz = bz;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic start_burst(input logic [1:0] sel, input logic [CYC_W-1:0] bc);
    cs_sel       = sel;
    burst_cycles = bc;
    start        = 1'b1;
    t0           = cyc;
    tick(1);
    start = 1'b0;
  endtask

  // Monitor: flag events that never came, then match every emitted strobe or done.
  always @(negedge clk) begin
    if (rstn) begin
      mon_act = {spi_rise, spi_fall, spi_shift, spi_sample, spi_last, done};
      while (q.size() > 0 && q[0].cyc < cyc) begin
        checks++;
        failures++;
        $display("FAIL missed_event: cycle %0d flags %b never seen (now %0d)",
                 q[0].cyc, q[0].fl, cyc);
        q.delete(0);
      end
      if (mon_act != 6'b0) begin
        checks++;
        if (q.size() == 0) begin
          failures++;
          $display("FAIL unexpected_event: cycle %0d flags %b clk %b busy %b, nothing expected",
                   cyc, mon_act, spi_clk, busy);
        end else begin
          mon_e = q.pop_front();
          if (mon_e.cyc != cyc || mon_e.fl != mon_act || mon_e.ck !== spi_clk || mon_e.bz !== busy) begin
            failures++;
            $display("FAIL event: got cycle %0d flags %b clk %b busy %b, required cycle %0d flags %b clk %b busy %b",
                     cyc, mon_act, spi_clk, busy, mon_e.cyc, mon_e.fl, mon_e.ck, mon_e.bz);
          end
        end
      end
    end
  end

  initial begin
    rstn           = 1'b0;
    cfg_sck_period = '0;
    cfg_sck_period[0*CNT_W +: CNT_W] = 8'd4;
    cfg_sck_period[1*CNT_W +: CNT_W] = 8'd8;
    cfg_sck_period[2*CNT_W +: CNT_W] = 8'd5;
    cfg_sck_period[3*CNT_W +: CNT_W] = 8'd1;
    cfg_cpol     = 4'b0010;
    cfg_cpha     = 4'b0100;
    cs_sel       = 2'd3;
    burst_cycles = '0;
    start        = 1'b0;
    sck_stall    = 1'b0;
    abort        = 1'b0;
    tick(3);

    // Reset values: spi_clk=1 even though the selected slot has cpol=0.
    chk("reset_spi_clk", {31'b0, spi_clk}, 32'd1);
    chk("reset_outputs", {26'b0, busy, done, spi_rise, spi_fall, spi_shift, spi_sample},
        32'd0);
    chk("reset_last", {31'b0, spi_last}, 32'd0);
    rstn = 1'b1;
    cfg_cpol[0] = 1'b1;
    cs_sel = 2'd0;
    tick(3);
    chk("idle_clk_cpol1", {31'b0, spi_clk}, 32'd1);

    // Burst 1: P=4 cpol=1 cpha=0 N=2.
    start_burst(2'd0, 6'd1);
    push(t0+2, F|SA, 1'b1, 1'b1);
    push(t0+4, R|SH, 1'b0, 1'b1);
    push(t0+6, F|SA, 1'b1, 1'b1);
    push(t0+8, R|SH|L, 1'b0, 1'b1);
    push(t0+9, D, 1'b1, 1'b0);
    chk("b1_busy_t1", {31'b0, busy}, 32'd1);
    tick(10);
    $display("burst1 P=4 cpol=1 cpha=0 N=2 started at cycle %0d", t0);

    // Burst 2: slot 2, P=5 cpol=0 cpha=1 N=1.
    cs_sel = 2'd2;
    tick(3);
    chk("idle_clk_cpol0", {31'b0, spi_clk}, 32'd0);
    start_burst(2'd2, 6'd0);
    push(t0+2, R|SH, 1'b0, 1'b1);
    push(t0+5, F|SA|L, 1'b1, 1'b1);
    push(t0+6, D, 1'b0, 1'b0);
    tick(2);
    chk("b2_clk_t3", {31'b0, spi_clk}, 32'd1);
    tick(6);
    $display("burst2 slot2 P=5 cpol=0 cpha=1 N=1 started at cycle %0d", t0);

    // Burst 3: P=4 N=1 with sck_stall high in cycles t1..t3.
    cs_sel = 2'd0;
    tick(3);
    start_burst(2'd0, 6'd0);
    push(t0+5, F|SA, 1'b1, 1'b1);
    push(t0+7, R|SH|L, 1'b0, 1'b1);
    push(t0+8, D, 1'b1, 1'b0);
    sck_stall = 1'b1;
    tick(3);
    sck_stall = 1'b0;
    tick(7);
    $display("burst3 P=4 N=1 stalled t1..t3 started at cycle %0d", t0);

    // Burst 4: slot 1 P=8 cpol=1 N=4, aborted at t3; restart at t5.
    cs_sel = 2'd1;
    tick(3);
    start_burst(2'd1, 6'd3);
    tick(2);
    abort = 1'b1;
    chk("abort_busy_t3", {31'b0, busy}, 32'd1);
    tick(1);
    abort = 1'b0;
    chk("abort_clk_t4", {31'b0, spi_clk}, 32'd1);
    chk("abort_busy_t4", {31'b0, busy}, 32'd0);
    tick(1);
    $display("burst4 slot1 P=8 N=4 aborted, started at cycle %0d", t0);
    start_burst(2'd0, 6'd0);
    push(t0+2, F|SA, 1'b1, 1'b1);
    push(t0+4, R|SH|L, 1'b0, 1'b1);
    push(t0+5, D, 1'b1, 1'b0);
    chk("restart_busy", {31'b0, busy}, 32'd1);
    tick(8);
    $display("burst5 restart after abort at cycle %0d", t0);

    // Burst 6: slot 3 P=1 (runs as 2) cpol=0 cpha=0 N=2; config churn and start while busy.
    cs_sel = 2'd3;
    tick(3);
    start_burst(2'd3, 6'd1);
    push(t0+1, R|SA, 1'b0, 1'b1);
    push(t0+2, F|SH, 1'b1, 1'b1);
    push(t0+3, R|SA, 1'b0, 1'b1);
    push(t0+4, F|SH|L, 1'b1, 1'b1);
    push(t0+5, D, 1'b0, 1'b0);
    start  = 1'b1;
    cs_sel = 2'd0;
    cfg_sck_period[3*CNT_W +: CNT_W] = 8'd9;
    tick(1);
    start = 1'b0;
    tick(9);
    chk("no_second_burst", {31'b0, busy}, 32'd0);
    $display("burst6 P=1 as P=2 N=2 with mid-burst changes at cycle %0d", t0);

    // Burst 7: P=2 with the full 64-cycle burst length.
    cfg_sck_period[3*CNT_W +: CNT_W] = 8'd2;
    cs_sel = 2'd3;
    tick(3);
    start_burst(2'd3, 6'd63);
    for (int k = 0; k < 64; k++) begin
      push(t0+2*k+1, R|SA, 1'b0, 1'b1);
      push(t0+2*k+2, (k == 63) ? (F|SH|L) : (F|SH), 1'b1, 1'b1);
    end
    push(t0+129, D, 1'b0, 1'b0);
    tick(135);
    $display("burst7 P=2 N=64 started at cycle %0d", t0);

    // Burst 8: asynchronous reset mid-burst while spi_clk is low.
    cfg_cpol[1] = 1'b0;
    cs_sel = 2'd1;
    tick(3);
    start_burst(2'd1, 6'd3);
    tick(1);
    chk("prereset_clk_low", {31'b0, spi_clk}, 32'd0);
    #2;
    rstn = 1'b0;
    #1;
    chk("async_reset_clk", {31'b0, spi_clk}, 32'd1);
    chk("async_reset_busy", {31'b0, busy}, 32'd0);
    tick(2);
    rstn = 1'b1;
    tick(3);
    chk("after_reset_idle", {31'b0, busy}, 32'd0);
    $display("burst8 reset mid-burst at cycle %0d", t0);

    chk("scoreboard_drained", q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
